// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, drives the instruction bus, and buffers responses in a DEPTH-entry FIFO for decode.
// Optional feature macro FETCH_MISALIGN_CHECK_EN: misaligned PCs become a queued fetch exception instead of a bus request.
//
// state   | meaning
// IDLE    | no request outstanding
// WAIT    | request outstanding, response will be queued
// DISCARD | request outstanding, response will be dropped (redirected)

module fetch_queue #(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_excp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_W / 8);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  req_addr, req_addr_nxt;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_after_push;
  logic               push, pop, flush, room_after_push;
  logic [INSTR_W-1:0] push_instr;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int OFF_W = $clog2(INSTR_W / 8);
  logic halt, halt_nxt;
  logic push_excp;
  logic excp_mem [DEPTH];
  logic pc_misaligned;
  assign pc_misaligned = |pc[OFF_W-1:0];
`endif

  // A redirect clears the queue, so a pop in the same cycle has nothing to remove.
  assign pop = out_valid && out_ready && !redirect_valid;
  assign flush = redirect_valid;
  assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);
  assign room_after_push = count_after_push < DEPTH_CNT;

  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    req_addr_nxt = req_addr;
    push = 1'b0;
    push_instr = iresp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    halt_nxt = halt;
    push_excp = 1'b0;
`endif
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      state_nxt = (state != S_IDLE && !iresp_data_ok) ? S_DISCARD : S_IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_nxt = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (count < DEPTH_CNT) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (!halt) begin
              if (pc_misaligned) begin
                push = 1'b1;
                push_excp = 1'b1;
                push_instr = '0;
                halt_nxt = 1'b1;
              end else begin
                state_nxt = S_WAIT;
                req_addr_nxt = pc;
              end
            end
`else
            state_nxt = S_WAIT;
            req_addr_nxt = pc;
`endif
          end
        end
        S_WAIT: begin
          if (iresp_data_ok) begin
            push = 1'b1;
            pc_nxt = pc + PC_INC;
            // Keep the request line up for back-to-back fetch when the slot is guaranteed.
            if (room_after_push) begin
              req_addr_nxt = pc + PC_INC;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (iresp_data_ok) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      pc <= PC_RESET;
      req_addr <= PC_RESET;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      req_addr <= req_addr_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt <= halt_nxt;
`endif
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= pc;
      instr_mem[wr_ptr] <= push_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      excp_mem[wr_ptr] <= push_excp;
`endif
    end
  end

  assign ireq_valid = (state != S_IDLE);
  assign ireq_addr = req_addr;
  assign out_valid = (count != '0);
  assign out_pc = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_excp = out_valid && excp_mem[rd_ptr];
`else
  assign out_excp = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run checked by a queue-based reference model.
// The misalignment scenario runs only when FETCH_MISALIGN_CHECK_EN is defined.

module tb_fetch_queue;

  localparam int ADDR_W = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;
  localparam logic [63:0] PC_RST = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_excp;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  int bus_lat = 0;
  bit bus_rand = 0;
  int bus_cnt = 0;
  int cur_lat = 0;
  bit mon_en = 1;

  ent_t        mq[$];
  logic [63:0] m_req;
  bit          m_squash;
  bit          m_hold;
  logic [63:0] m_hold_addr;

  fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_RESET(PC_RST)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_excp(out_excp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish by %0t", $time);
    $fatal(1);
  end

  // Bus model: answers each request after cur_lat extra cycles with random data.
  always begin
    @(posedge clk);
    #1;
    if (!resetn || !ireq_valid) begin
      iresp_data_ok = 1'b0;
      bus_cnt = 0;
      cur_lat = bus_rand ? int'($urandom_range(0, 3)) : bus_lat;
    end else if (bus_cnt >= cur_lat) begin
      iresp_data_ok = 1'b1;
      iresp_data = $urandom;
      bus_cnt = 0;
      cur_lat = bus_rand ? int'($urandom_range(0, 3)) : bus_lat;
    end else begin
      iresp_data_ok = 1'b0;
      bus_cnt++;
    end
  end

  // Reference model: in-order queue of accepted responses, next request address, pending squash.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!resetn) begin
        n_checks++;
        if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_in_reset: ireq_valid=%b out_valid=%b, required 0/0", ireq_valid, out_valid);
        end
        mq.delete();
        m_req = PC_RST;
        m_squash = 0;
        m_hold = 0;
      end else begin
        n_checks++;
        if (out_valid !== (mq.size() != 0)) begin
          n_fail++;
          $display("FAIL mon_out_valid: got %b, model holds %0d entries", out_valid, mq.size());
        end
        if (out_valid === 1'b1 && mq.size() != 0) begin
          n_checks++;
          if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
            n_fail++;
            $display("FAIL mon_head: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, mq[0].pc, mq[0].instr);
          end
        end
`ifndef FETCH_MISALIGN_CHECK_EN
        n_checks++;
        if (out_excp !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_excp: got %b, required 0", out_excp);
        end
`endif
        if (ireq_valid === 1'b1 && !m_squash) begin
          n_checks++;
          if (ireq_addr !== m_req) begin
            n_fail++;
            $display("FAIL mon_req_addr: got %h, required %h", ireq_addr, m_req);
          end
        end
        n_checks++;
        if (mq.size() + ((ireq_valid === 1'b1 && !m_squash) ? 1 : 0) > DEPTH) begin
          n_fail++;
          $display("FAIL mon_credit: %0d queued plus live request exceeds %0d", mq.size(), DEPTH);
        end
        if (m_hold) begin
          n_checks++;
          if (ireq_valid !== 1'b1 || ireq_addr !== m_hold_addr) begin
            n_fail++;
            $display("FAIL mon_req_hold: got valid=%b addr=%h, required 1 and %h", ireq_valid, ireq_addr, m_hold_addr);
          end
        end
        m_hold = (ireq_valid === 1'b1) && !iresp_data_ok;
        m_hold_addr = ireq_addr;
        if (redirect_valid) begin
          mq.delete();
          m_req = redirect_pc;
          m_squash = (ireq_valid === 1'b1) && !iresp_data_ok;
        end else begin
          if (out_valid === 1'b1 && out_ready && mq.size() != 0) void'(mq.pop_front());
          if (ireq_valid === 1'b1 && iresp_data_ok) begin
            if (m_squash) m_squash = 0;
            else begin
              mq.push_back('{pc: m_req, instr: iresp_data});
              m_req = m_req + 64'd4;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit seen = 0;
    resetn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ireq_valid: got %b, required 0", ireq_valid); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (out_excp !== 1'b0) begin n_fail++; $display("FAIL reset_out_excp: got %b, required 0", out_excp); end
    resetn = 1'b1;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (ireq_valid === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || ireq_addr !== PC_RST) begin
      n_fail++;
      $display("FAIL reset_first_req: seen=%0d addr=%h, required 1 and %h", seen, ireq_addr, PC_RST);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] pcs[3];
    int cycs[3];
    int got = 0;
    bus_lat = 0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && got < 3; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        pcs[got] = out_pc;
        cycs[got] = cyc;
        got++;
      end
    end
    n_checks++;
    if (got != 3) begin n_fail++; $display("FAIL seq_count: got %0d outputs, required 3", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++;
      if (pcs[i] !== PC_RST + 64'(4 * i) || cycs[i] != cycs[0] + i) begin
        n_fail++;
        $display("FAIL seq_out_%0d: got pc=%h at +%0d cycles, required %h at +%0d",
                 i, pcs[i], cycs[i] - cycs[0], PC_RST + 64'(4 * i), i);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    bit resumed = 0;
    logic [63:0] pcs[5];
    bus_lat = 0;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ireq_valid === 1'b1 && iresp_data_ok) acc++;
    end
    n_checks++;
    if (acc != DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d, required %0d", acc, DEPTH); end
    n_checks++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stalled: ireq_valid=%b out_valid=%b, required 0/1", ireq_valid, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 15 && got < 5; i++) begin
      if (out_valid === 1'b1) begin pcs[got] = out_pc; got++; end
      if (ireq_valid === 1'b1 && ireq_addr === PC_RST + 64'h10) resumed = 1;
      tick();
    end
    n_checks++;
    if (got != 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d, required 5", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++;
      if (pcs[i] !== PC_RST + 64'(4 * i)) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got %h, required %h", i, pcs[i], PC_RST + 64'(4 * i));
      end
    end
    n_checks++;
    if (!resumed) begin n_fail++; $display("FAIL bp_resume: request for %h seen=0, required 1", PC_RST + 64'h10); end
  endtask

  task automatic test_redirect_wait();
    bit found = 0;
    bit seen = 0;
    int bad = 0;
    logic [63:0] first_pc = '0;
    bus_lat = 3;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (ireq_valid === 1'b1 && ireq_addr === PC_RST + 64'h8 && !iresp_data_ok) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rw_reach_wait: request for 8000_0008 found=0, required 1"); end
    pulse_redirect(64'h8000_1000);
    n_checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== PC_RST + 64'h8) begin
      n_fail++;
      $display("FAIL rw_after_redirect: out_valid=%b ireq_valid=%b addr=%h, required 0/1/%h",
               out_valid, ireq_valid, ireq_addr, PC_RST + 64'h8);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin
        if (out_pc === PC_RST + 64'h8) bad++;
        if (!seen) begin first_pc = out_pc; seen = 1; end
      end
      tick();
    end
    n_checks++;
    if (!seen || first_pc !== 64'h8000_1000) begin
      n_fail++;
      $display("FAIL rw_first_out: seen=%0d pc=%h, required 1 and 8000_1000", seen, first_pc);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rw_squash: discarded pc appeared %0d times, required 0", bad); end
    bus_lat = 0;
  endtask

  task automatic test_redirect_coincident();
    bit seen = 0;
    bus_lat = 0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (ireq_valid !== 1'b1 || iresp_data_ok !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rc_stream: ireq_valid=%b data_ok=%b out_valid=%b, required 1/1/1",
               ireq_valid, iresp_data_ok, out_valid);
    end
    pulse_redirect(64'h8000_1000);
    n_checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rc_flushed: out_valid=%b ireq_valid=%b, required 0/0", out_valid, ireq_valid);
    end
    for (int i = 0; i < 5 && !seen; i++) begin
      if (ireq_valid === 1'b1) seen = 1;
      else tick();
    end
    n_checks++;
    if (!seen || ireq_addr !== 64'h8000_1000) begin
      n_fail++;
      $display("FAIL rc_next_req: seen=%0d addr=%h, required 1 and 8000_1000", seen, ireq_addr);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] want[4];
    logic [63:0] pcs[4];
    int got = 0;
    want[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    want[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    want[2] = 64'h0;
    want[3] = 64'h4;
    bus_lat = 1;
    out_ready = 1'b1;
    pulse_redirect(want[0]);
    for (int i = 0; i < 30 && got < 4; i++) begin
      if (out_valid === 1'b1) begin pcs[got] = out_pc; got++; end
      tick();
    end
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL wrap_count: got %0d, required 4", got); end
    for (int i = 0; i < got; i++) begin
      n_checks++;
      if (pcs[i] !== want[i]) begin n_fail++; $display("FAIL wrap_%0d: got %h, required %h", i, pcs[i], want[i]); end
    end
    bus_lat = 0;
  endtask

  task automatic test_random();
    int pops = 0;
    int r;
    logic [63:0] pc;
    bus_rand = 1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6) pc = 64'h8000_0000 | 64'($urandom & 32'h000F_FFFC);
        else if (r < 8) pc = 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(0, 3)) << 2);
`ifndef FETCH_MISALIGN_CHECK_EN
        else pc = 64'h8000_0000 + 64'($urandom_range(0, 7));
`else
        else pc = 64'h9000_0000;
`endif
        redirect_valid = 1'b1;
        redirect_pc = pc;
      end
      tick();
      redirect_valid = 1'b0;
    end
    bus_rand = 0;
    bus_lat = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1) pops++;
    end
    n_checks++;
    if (pops < 10) begin n_fail++; $display("FAIL rand_liveness: %0d outputs in 20 cycles, required at least 10", pops); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit seen = 0;
    bus_lat = 2;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (ireq_valid === 1'b1 && out_valid === 1'b1 && !iresp_data_ok) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rm_setup: WAIT with queued data found=0, required 1"); end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async_clear: ireq_valid=%b out_valid=%b, required 0/0", ireq_valid, out_valid);
    end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (ireq_valid === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || ireq_addr !== PC_RST || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_restart: seen=%0d addr=%h out_valid=%b, required 1/%h/0", seen, ireq_addr, out_valid, PC_RST);
    end
    bus_lat = 0;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    int reqs = 0;
    bit seen = 0;
    mon_en = 0;
    bus_lat = 0;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    pulse_redirect(64'h8000_0002);
    for (int i = 0; i < 6; i++) begin
      if (ireq_valid === 1'b1) reqs++;
      tick();
    end
    n_checks++;
    if (reqs != 0) begin n_fail++; $display("FAIL mis_no_req: %0d request cycles, required 0", reqs); end
    n_checks++;
    if (out_valid !== 1'b1 || out_excp !== 1'b1 || out_pc !== 64'h8000_0002) begin
      n_fail++;
      $display("FAIL mis_entry: valid=%b excp=%b pc=%h, required 1/1/8000_0002", out_valid, out_excp, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_stall: out_valid=%b ireq_valid=%b, required 0/0", out_valid, ireq_valid);
    end
    pulse_redirect(64'h8000_2000);
    for (int i = 0; i < 5 && !seen; i++) begin
      if (ireq_valid === 1'b1) seen = 1;
      else tick();
    end
    n_checks++;
    if (!seen || ireq_addr !== 64'h8000_2000) begin
      n_fail++;
      $display("FAIL mis_resume: seen=%0d addr=%h, required 1 and 8000_2000", seen, ireq_addr);
    end
    resetn = 1'b0;
    mon_en = 1;
    tick();
    resetn = 1'b1;
  endtask
`endif

  initial begin
    resetn = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
